// File: rtl/dmem_pkg.sv
// Shared encodings and defaults for the data-memory controller.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RMW_WRITE = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_merge.sv
// Lane merge for sub-word stores: overlays byte/half store data onto the old RAM word.
module dmem_merge
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [15:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] new_word
);

    always_comb begin
        new_word = old_word;
        if (size == SZ_BYTE) begin
            new_word[{offset, 3'b000} +: 8] = wdata[7:0];
        end else if (size == SZ_HALF) begin
            if (offset[1]) begin
                new_word[31:16] = wdata;
            end else begin
                new_word[15:0] = wdata;
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: aligned loads, word stores, and read-modify-write
// for byte/half stores against a synchronous-read single-port RAM.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       mem_data,
    output logic              misalign,
    output logic [31:0]       stall_cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout
);

    state_e            state_q, state_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic        req_is_word;
    logic        req_misaligned;
    logic        req_live;
    logic [31:0] merged_word;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Size 2'b11 behaves as a word access.
    assign req_is_word    = req_size[1];
    assign req_misaligned = req_is_word ? (req_addr[1:0] != 2'b00)
                                        : ((req_size == SZ_HALF) && req_addr[0]);
    // Qualify with rst_n so IDLE outputs go quiet the moment reset asserts.
    assign req_live       = req_valid && rst_n;

    dmem_merge u_merge (
        .old_word (ram_dout),
        .wdata    (wdata_q),
        .size     (size_q),
        .offset   (addr_q[1:0]),
        .new_word (merged_word)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        mem_data_d = mem_data_q;
        stall      = 1'b0;
        done       = 1'b0;
        misalign   = 1'b0;
        ram_we     = 1'b0;
        ram_din    = '0;
        ram_addr   = addr_q[ADDR_W+1:2];
        mem_data   = mem_data_q;

        unique case (state_q)
            IDLE: begin
                ram_addr = req_addr[ADDR_W+1:2];
                if (req_live) begin
                    if (req_misaligned) begin
                        misalign = 1'b1;
                        done     = 1'b1;
                    end else if (req_write && req_is_word) begin
                        ram_we  = 1'b1;
                        ram_din = req_wdata;
                        done    = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        addr_d  = req_addr[ADDR_W+1:0];
                        size_d  = req_is_word ? SZ_WORD : req_size;
                        wdata_d = req_wdata[15:0];
                        state_d = req_write ? RMW_WRITE : LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                mem_data   = ram_dout;
                mem_data_d = ram_dout;
                done       = 1'b1;
                state_d    = IDLE;
            end
            RMW_WRITE: begin
                ram_we  = 1'b1;
                ram_din = merged_word;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            mem_data_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            mem_data_q  <= mem_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a synchronous-read RAM model.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = SZ_WORD;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          stall, done, misalign, ram_we;
    logic [31:0]   mem_data, stall_cnt, ram_din;
    logic [31:0]   ram_dout = '0;
    logic [AW-1:0] ram_addr;

    logic [31:0] mem [0:(1<<AW)-1];
    int n_vec = 0;
    int n_bad = 0;

    dmem_ctrl #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .mem_data  (mem_data),
        .misalign  (misalign),
        .stall_cnt (stall_cnt),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = v;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        mem[2] = 32'h12345678;
        mem[5] = 32'h01020304;

        // Reset held with a valid word store presented: everything must stay quiet.
        drive(1'b1, 1'b1, SZ_WORD, 32'h0, 32'hFFFFFFFF);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Load word presented as reset deasserts.
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_addr = 32'h0;
        #1;
        chk("ld_stall_T", stall, 1);
        chk("ld_done_T", done, 0);
        chk("ld_addr_T", ram_addr, 0);
        idle();
        chk("ld_done_T1", done, 1);
        chk("ld_stall_T1", stall, 0);
        chk("ld_data_T1", mem_data, 32'h11223344);
        chk("ld_cnt", stall_cnt, 1);
        idle();
        chk("ld_hold", mem_data, 32'h11223344);
        chk("ld_done_T2", done, 0);

        // Byte store 0x55 to 0x6.
        drive(1'b1, 1'b1, SZ_BYTE, 32'h6, 32'h00000055);
        chk("sb_stall_T", stall, 1);
        chk("sb_we_T", ram_we, 0);
        idle();
        chk("sb_we_T1", ram_we, 1);
        chk("sb_din_T1", ram_din, 32'hAA55CCDD);
        chk("sb_addr_T1", ram_addr, 1);
        chk("sb_done_T1", done, 1);
        idle();
        chk("sb_ram", mem[1], 32'hAA55CCDD);
        chk("sb_cnt", stall_cnt, 2);

        // Half store 0xBEEF to 0xA.
        drive(1'b1, 1'b1, SZ_HALF, 32'hA, 32'h0000BEEF);
        chk("sh_stall_T", stall, 1);
        idle();
        chk("sh_din_T1", ram_din, 32'hBEEF5678);
        chk("sh_we_T1", ram_we, 1);
        idle();
        chk("sh_ram", mem[2], 32'hBEEF5678);
        chk("sh_cnt", stall_cnt, 3);

        // Misaligned word store to 0x3.
        drive(1'b1, 1'b1, SZ_WORD, 32'h3, 32'hDEADBEEF);
        chk("mis_flag", misalign, 1);
        chk("mis_done", done, 1);
        chk("mis_stall", stall, 0);
        chk("mis_we", ram_we, 0);
        drive(1'b1, 1'b0, 2'b11, 32'h2, 32'h0);
        chk("mis_sz3", misalign, 1);
        drive(1'b1, 1'b0, SZ_HALF, 32'h1, 32'h0);
        chk("mis_half", misalign, 1);
        idle();
        chk("mis_ram", mem[0], 32'h11223344);
        chk("mis_clear", misalign, 0);
        chk("mis_cnt", stall_cnt, 3);

        // Byte store to lane 0 ignores upper wdata bits.
        drive(1'b1, 1'b1, SZ_BYTE, 32'h10, 32'h123456FF);
        idle();
        chk("sb0_din", ram_din, 32'h000000FF);

        // Back-to-back: word store then load of the same word, no bubble.
        drive(1'b1, 1'b1, SZ_WORD, 32'hC, 32'hCAFEF00D);
        chk("b2b_we", ram_we, 1);
        chk("b2b_din", ram_din, 32'hCAFEF00D);
        chk("b2b_done", done, 1);
        chk("b2b_stall", stall, 0);
        drive(1'b1, 1'b0, 2'b11, 32'hC, 32'h0);
        chk("b2b_ld_stall", stall, 1);
        idle();
        chk("b2b_ld_data", mem_data, 32'hCAFEF00D);
        chk("b2b_ld_done", done, 1);
        chk("b2b_cnt", stall_cnt, 5);

        // Reset asserted while in RMW_WRITE.
        drive(1'b1, 1'b1, SZ_BYTE, 32'h14, 32'h00000099);
        chk("rmw_stall", stall, 1);
        idle();
        chk("rmw_we_pre", ram_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_we", ram_we, 0);
        chk("rmw_rst_done", done, 0);
        chk("rmw_rst_stall", stall, 0);
        chk("rmw_rst_mis", misalign, 0);
        chk("rmw_rst_data", mem_data, 0);
        chk("rmw_rst_cnt", stall_cnt, 0);
        idle();
        chk("rmw_rst_ram", mem[5], 32'h01020304);

        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_addr = 32'h14;
        #1;
        chk("post_rst_stall", stall, 1);
        idle();
        chk("post_rst_data", mem_data, 32'h01020304);

        // Forced saturation of the stall counter.
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.stall_cnt_q;
        chk("sat_preset", stall_cnt, 32'hFFFFFFFE);
        drive(1'b1, 1'b0, SZ_WORD, 32'h0, 32'h0);
        idle();
        chk("sat_max", stall_cnt, 32'hFFFFFFFF);
        drive(1'b1, 1'b0, SZ_WORD, 32'h0, 32'h0);
        idle();
        chk("sat_hold", stall_cnt, 32'hFFFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
